// File: rtl/axi2s_pkg.sv
// Shared types and constants for the AXI write-burst scheduler.
package axi2s_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_PRE  = 3'd2,
      S_DATA = 3'd3,
      S_RESP = 3'd4
   } state_t;

   localparam int unsigned BURST_LEN  = 16;
   localparam logic [63:0] ALIGN_MASK = 64'h0000_0000_0000_003f;
   localparam logic [1:0]  BRESP_OKAY = 2'b00;

   // Fixed AW/W fields driven as constants by the wrapper around this block
   localparam logic [3:0]  AXI_AWLEN   = 4'hf;
   localparam logic [2:0]  AXI_AWSIZE  = 3'b010;
   localparam logic [1:0]  AXI_AWBURST = 2'b01;
   localparam logic [5:0]  AXI_AWID    = 6'h3f;
   localparam logic [3:0]  AXI_WSTRB   = 4'hf;

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin pick: first requester at or after the pointer.
module rr_arbiter_n #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDXW = 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDXW-1:0] i_ptr,
   output logic [NREQ-1:0] o_gnt_oh_c,
   output logic [IDXW-1:0] o_gnt_idx_c,
   output logic            o_any_c
);

   int unsigned     w_j;
   logic [IDXW-1:0] w_jx;

   // Scan cyclically from the pointer, keep the first hit
   always_comb begin
      o_gnt_oh_c  = '0;
      o_gnt_idx_c = '0;
      o_any_c     = 1'b0;
      w_j         = 0;
      w_jx        = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         w_j = 32'(i_ptr) + k;
         if (w_j >= NREQ) w_j = w_j - NREQ;
         w_jx = IDXW'(w_j);
         if (!o_any_c && i_req[w_jx]) begin
            o_any_c          = 1'b1;
            o_gnt_oh_c[w_jx] = 1'b1;
            o_gnt_idx_c      = w_jx;
         end
      end
   end

endmodule

// File: rtl/axi_wburst_arb.sv
// Round-robin scheduler sharing one AXI write channel between NREQ producers.
module axi_wburst_arb #(
   parameter int unsigned NREQ      = 2,
   parameter int unsigned BURST_LEN = axi2s_pkg::BURST_LEN,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned B_TIMEOUT = 1024
) (
   input  logic                     AXI_clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ-1:0]          req_half,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          done,
   output logic [NREQ-1:0]          err,
   output logic [NREQ-1:0]          buf_en,
   output logic [4:0]               buf_addr,
   input  logic [NREQ*DATA_W-1:0]   buf_data,
   output logic [ADDR_W-1:0]        AXI_awaddr,
   output logic                     AXI_awvalid,
   input  logic                     AXI_awready,
   output logic [DATA_W-1:0]        AXI_wdata,
   output logic                     AXI_wvalid,
   input  logic                     AXI_wready,
   output logic                     AXI_wlast,
   input  logic                     AXI_bvalid,
   output logic                     AXI_bready,
   input  logic [1:0]               AXI_bresp,
   output logic                     busy
);
   import axi2s_pkg::*;

   localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned TW   = (B_TIMEOUT > 1) ? $clog2(B_TIMEOUT) : 1;

   state_t            r_state;
   logic [IDXW-1:0]   r_ptr;
   logic [IDXW-1:0]   r_idx;
   logic [NREQ-1:0]   r_oh;
   logic [ADDR_W-1:0] r_awaddr;
   logic              r_half;
   logic [3:0]        r_beat;
   logic [TW-1:0]     r_tmo;
   logic [NREQ-1:0]   r_gnt, r_done, r_err;
   logic              r_awvalid, r_wvalid, r_wlast, r_bready, r_busy;

   logic [NREQ-1:0]   w_arb_oh;
   logic [IDXW-1:0]   w_arb_idx;
   logic              w_arb_any;
   logic [ADDR_W-1:0] w_req_addr;
   logic              w_last;

   rr_arbiter_n #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
      .i_req       (req),
      .i_ptr       (r_ptr),
      .o_gnt_oh_c  (w_arb_oh),
      .o_gnt_idx_c (w_arb_idx),
      .o_any_c     (w_arb_any)
   );

   assign w_req_addr = req_addr[32'(w_arb_idx)*ADDR_W +: ADDR_W];
   assign w_last     = (r_beat == 4'(BURST_LEN - 1));

   // RAM read port: prefetch word 0 in PRE, next word on each accepted beat
   always_comb begin
      buf_en   = '0;
      buf_addr = '0;
      if (r_state == S_PRE) begin
         buf_en   = r_oh;
         buf_addr = {r_half, 4'd0};
      end else if (r_state == S_DATA && AXI_wready && !w_last) begin
         buf_en   = r_oh;
         buf_addr = {r_half, r_beat + 4'd1};
      end
   end

   // W data taken straight from the granted producer's RAM output
   always_comb begin
      AXI_wdata = '0;
      for (int unsigned p = 0; p < NREQ; p++) begin
         if (r_wvalid && r_idx == IDXW'(p)) AXI_wdata = buf_data[p*DATA_W +: DATA_W];
      end
   end

   // Burst FSM with registered AXI handshake and status outputs
   always_ff @(posedge AXI_clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_idx     <= '0;
         r_oh      <= '0;
         r_awaddr  <= '0;
         r_half    <= 1'b0;
         r_beat    <= '0;
         r_tmo     <= '0;
         r_gnt     <= '0;
         r_done    <= '0;
         r_err     <= '0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_wlast   <= 1'b0;
         r_bready  <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_gnt  <= '0;
         r_done <= '0;
         r_err  <= '0;
         case (r_state)
            S_IDLE: begin
               r_bready <= 1'b1;
               if (w_arb_any) begin
                  r_idx     <= w_arb_idx;
                  r_oh      <= w_arb_oh;
                  r_awaddr  <= w_req_addr & ~ADDR_W'(ALIGN_MASK);
                  r_half    <= req_half[w_arb_idx];
                  r_ptr     <= (w_arb_idx == IDXW'(NREQ - 1)) ? '0 : w_arb_idx + 1'b1;
                  r_awvalid <= 1'b1;
                  r_bready  <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (AXI_awready) begin
                  r_gnt     <= r_oh;
                  r_awvalid <= 1'b0;
                  r_state   <= S_PRE;
               end
            end
            S_PRE: begin
               r_beat   <= '0;
               r_wvalid <= 1'b1;
               r_wlast  <= (BURST_LEN == 1);
               r_state  <= S_DATA;
            end
            S_DATA: begin
               if (AXI_wready) begin
                  if (w_last) begin
                     r_wvalid <= 1'b0;
                     r_wlast  <= 1'b0;
                     r_bready <= 1'b1;
                     r_tmo    <= '0;
                     r_state  <= S_RESP;
                  end else begin
                     r_beat  <= r_beat + 4'd1;
                     r_wlast <= ((r_beat + 4'd1) == 4'(BURST_LEN - 1));
                  end
               end
            end
            S_RESP: begin
               if (AXI_bvalid) begin
                  if (AXI_bresp == BRESP_OKAY) r_done <= r_oh;
                  else                         r_err  <= r_oh;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (r_tmo == TW'(B_TIMEOUT - 1)) begin
                  r_err   <= r_oh;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt         = r_gnt;
   assign done        = r_done;
   assign err         = r_err;
   assign AXI_awaddr  = r_awaddr;
   assign AXI_awvalid = r_awvalid;
   assign AXI_wvalid  = r_wvalid;
   assign AXI_wlast   = r_wlast;
   assign AXI_bready  = r_bready;
   assign busy        = r_busy;

endmodule

// File: tb/tb_axi_wburst_arb.sv
// Scoreboard bench for axi_wburst_arb with two producers.
module tb_axi_wburst_arb;

   localparam int unsigned NREQ = 2;
   localparam int unsigned BTO  = 1024;

   typedef struct packed {
      logic        last;
      logic [31:0] d;
   } wexp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [63:0] req_addr;
   logic [1:0]  req_half;
   logic [1:0]  gnt, done, err, buf_en;
   logic [4:0]  buf_addr;
   logic [63:0] buf_data;
   logic [31:0] awaddr, wdata;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready, busy;
   logic [1:0]  bresp;

   logic [31:0] mem [2][32];
   logic [31:0] ram_q [2];

   logic [31:0] exp_aw [$];
   logic [1:0]  exp_gnt [$];
   wexp_t       exp_w [$];
   logic [3:0]  exp_b [$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int w_hs    = 0;
   int gnt_cnt = 0;
   int last_aw_cyc, last_w_cyc, busy_run;
   logic [1:0] cur_oh;
   logic tog_en, chk_busy, chk_period, chk_tmo;

   axi_wburst_arb #(.NREQ(NREQ), .B_TIMEOUT(BTO)) dut (
      .AXI_clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_half(req_half),
      .gnt(gnt), .done(done), .err(err), .buf_en(buf_en), .buf_addr(buf_addr),
      .buf_data(buf_data), .AXI_awaddr(awaddr), .AXI_awvalid(awvalid),
      .AXI_awready(awready), .AXI_wdata(wdata), .AXI_wvalid(wvalid),
      .AXI_wready(wready), .AXI_wlast(wlast), .AXI_bvalid(bvalid),
      .AXI_bready(bready), .AXI_bresp(bresp), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Producer RAMs: 1-cycle read latency, output holds when not enabled
   always @(posedge clk) begin
      for (int p = 0; p < 2; p++)
         if (buf_en[p]) ram_q[p] <= mem[p][buf_addr];
   end
   assign buf_data = {ram_q[1], ram_q[0]};

   // W-channel backpressure: steady or alternating
   always @(posedge clk) begin
      #1;
      if (tog_en) wready = ~wready;
      else        wready = 1'b1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Queue up everything one burst from producer p should produce
   task automatic issue(input int p, input logic [31:0] a, input logic h, input logic is_err);
      logic [4:0] ix;
      logic [1:0] oh;
      oh = 2'(1 << p);
      req_addr[p*32 +: 32] = a;
      req_half[p] = h;
      exp_aw.push_back(a & 32'hffff_ffc0);
      exp_gnt.push_back(oh);
      for (int i = 0; i < 16; i++) begin
         ix = {h, 4'(i)};
         exp_w.push_back({(i == 15), mem[p][ix]});
      end
      exp_b.push_back(is_err ? {oh, 2'b00} : {2'b00, oh});
   endtask

   task automatic wait_gnt(input int p);
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge clk); #1;
         if (gnt[p]) break;
      end
      check("gnt_wait", 64'(k < 200), 1);
   endtask

   task automatic wait_done(input int limit);
      int k;
      for (k = 0; k < limit; k++) begin
         @(negedge clk); #1;
         if (exp_b.size() == 0 && exp_w.size() == 0 && !busy) break;
      end
      check("done_wait", 64'(k < limit), 1);
   endtask

   // Monitor: compare DUT output against scoreboard away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         last_aw_cyc = 0;
         busy_run    = 0;
      end else begin
         if (awvalid && awready) begin
            if (exp_aw.size() == 0) check("aw_unexp", 1, 0);
            else check("awaddr", awaddr, exp_aw.pop_front());
            if (chk_period && last_aw_cyc != 0) check("aw_period", 64'(cyc - last_aw_cyc), 20);
            last_aw_cyc = cyc;
         end
         if (gnt != 2'b00) begin
            if (exp_gnt.size() == 0) check("gnt_unexp", 64'(gnt), 0);
            else begin
               cur_oh = exp_gnt.pop_front();
               check("gnt", gnt, cur_oh);
            end
            gnt_cnt++;
         end
         if (wvalid) begin
            if (exp_w.size() == 0) check("w_unexp", 1, 0);
            else begin
               check("wdata", wdata, exp_w[0].d);
               if (wready) begin
                  check("wlast", wlast, exp_w[0].last);
                  check("hs_buf_en", buf_en, exp_w[0].last ? 2'b00 : cur_oh);
                  if (wlast) last_w_cyc = cyc + 1;
                  void'(exp_w.pop_front());
                  w_hs++;
               end else begin
                  check("stall_buf_en", buf_en, 0);
               end
            end
         end
         if ((done | err) != 2'b00) begin
            if (exp_b.size() == 0) check("b_unexp", {err, done}, 0);
            else check("b_status", {err, done}, exp_b.pop_front());
            if (chk_tmo && err != 2'b00) check("tmo_lat", 64'(cyc - last_w_cyc), BTO);
         end
         if (busy) busy_run++;
         else begin
            if (chk_busy && busy_run > 0) check("busy_len", 64'(busy_run), 19);
            busy_run = 0;
         end
      end
   end

   initial begin
      int base;
      rst = 1'b1; req = '0; req_addr = '0; req_half = '0;
      awready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
      tog_en = 1'b0; chk_busy = 1'b0; chk_period = 1'b0; chk_tmo = 1'b0;
      cur_oh = '0; last_w_cyc = 0;
      ram_q[0] = '0; ram_q[1] = '0;
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 32; i++)
            mem[p][i] = {8'ha5, 4'(p), 3'd0, 5'(i), 12'($urandom)};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_awvalid", awvalid, 0);
      check("rst_busy", busy, 0);
      check("rst_bready", bready, 0);
      check("rst_flags", {gnt, done, err, buf_en}, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle_bready", bready, 1);

      // Single producer, half 1, unaligned address
      chk_busy = 1'b1;
      issue(0, 32'h1000_0047, 1'b1, 1'b0);
      req[0] = 1'b1;
      wait_gnt(0);
      @(posedge clk); #1; req[0] = 1'b0;
      wait_done(100);
      chk_busy = 1'b0;

      // Both request continuously from reset: 0,1,0,1
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      chk_period = 1'b1;
      issue(0, 32'h2000_0100, 1'b0, 1'b0);
      issue(1, 32'h3000_0200, 1'b1, 1'b0);
      issue(0, 32'h2000_0100, 1'b0, 1'b0);
      issue(1, 32'h3000_0200, 1'b1, 1'b0);
      base = gnt_cnt;
      req = 2'b11;
      for (int k = 0; k < 200 && gnt_cnt < base + 4; k++) begin
         @(negedge clk); #1;
      end
      check("alt_gnts", 64'(gnt_cnt - base), 4);
      @(posedge clk); #1; req = 2'b00;
      wait_done(200);
      chk_period = 1'b0;

      // W backpressure alternating
      tog_en = 1'b1;
      issue(1, 32'h4000_0abc, 1'b0, 1'b0);
      @(posedge clk); #1; req[1] = 1'b1;
      wait_gnt(1);
      @(posedge clk); #1; req[1] = 1'b0;
      wait_done(200);
      tog_en = 1'b0;

      // Error response
      bresp = 2'b10;
      issue(0, 32'h5000_0040, 1'b1, 1'b1);
      @(posedge clk); #1; req[0] = 1'b1;
      wait_gnt(0);
      @(posedge clk); #1; req[0] = 1'b0;
      wait_done(100);
      bresp = 2'b00;

      // B timeout, then a late bvalid absorbed in IDLE
      bvalid = 1'b0;
      chk_tmo = 1'b1;
      issue(1, 32'h6000_0000, 1'b0, 1'b1);
      @(posedge clk); #1; req[1] = 1'b1;
      wait_gnt(1);
      @(posedge clk); #1; req[1] = 1'b0;
      wait_done(BTO + 100);
      chk_tmo = 1'b0;
      @(posedge clk); #1; bvalid = 1'b1;
      check("late_bready", bready, 1);
      repeat (3) @(posedge clk);
      #1;
      check("late_busy", busy, 0);
      issue(0, 32'h7000_0080, 1'b0, 1'b0);
      req[0] = 1'b1;
      wait_gnt(0);
      @(posedge clk); #1; req[0] = 1'b0;
      wait_done(100);

      // Reset in the middle of DATA at beat 7
      issue(0, 32'h8000_0000, 1'b1, 1'b0);
      base = w_hs;
      @(posedge clk); #1; req[0] = 1'b1;
      wait_gnt(0);
      @(posedge clk); #1; req[0] = 1'b0;
      for (int k = 0; k < 100 && w_hs < base + 7; k++) begin
         @(negedge clk); #1;
      end
      check("mid_beats", 64'(w_hs - base), 7);
      @(posedge clk); #1; rst = 1'b1; #1;
      check("mid_rst_axi", {awvalid, wvalid, wlast, bready, busy}, 0);
      check("mid_rst_flags", {gnt, done, err, buf_en}, 0);
      check("mid_rst_addr", {awaddr, 5'(buf_addr)}, 0);
      check("mid_rst_wdata", wdata, 0);
      exp_w.delete(); exp_b.delete(); exp_aw.delete(); exp_gnt.delete();
      @(posedge clk); #1; rst = 1'b0;
      issue(1, 32'h9000_0010, 1'b1, 1'b0);
      @(posedge clk); #1; req[1] = 1'b1;
      wait_gnt(1);
      @(posedge clk); #1; req[1] = 1'b0;
      wait_done(100);

      check("sb_empty", 64'(exp_aw.size() + exp_gnt.size() + exp_w.size() + exp_b.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
